core_wb_bridge: RTL and testbench

CORE_WB_BRIDGE -- requirements
Module: core_wb_bridge

---
 rtl/core_bridge_pkg.sv | 17 +
 rtl/bridge_resp_stage.sv | 57 +++++
 rtl/core_wb_bridge.sv | 154 +++++++++++++++
 tb/tb_core_wb_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bridge_pkg.sv
// Shared definitions for the core-to-Wishbone bridge: controller states and
// the default values of the bridge parameters.
package core_bridge_pkg;

    // RUN: normal pipelined operation; ABORT: flushing requests after a bus timeout
    typedef enum logic {
        RUN   = 1'b0,
        ABORT = 1'b1
    } bridge_state_e;

    localparam int DEF_ADDR_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_MAX_OUTSTANDING = 2;
    localparam int DEF_RESP_REG        = 1;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;

endpackage

// File: rtl/bridge_resp_stage.sv
// Response return stage of the bridge. Either registers valid/data/error for
// one cycle or passes them straight through. Read data is forced to zero
// whenever no response is being presented.
module bridge_resp_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_REG   = 1
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  vld_in,
    input  logic                  err_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  vld_out,
    output logic                  err_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  pending
);

    generate
        if (RESP_REG != 0) begin : g_reg
            logic                  vld_p0;
            logic                  err_p0;
            logic [DATA_WIDTH-1:0] data_p0;

            // Control half of the response register; cleared by reset so
            // in-flight responses are dropped.
            always_ff @(posedge sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p0 <= 1'b0;
                    err_p0 <= 1'b0;
                end else begin
                    vld_p0 <= vld_in;
                    err_p0 <= vld_in & err_in;
                end
            end

            // Data half: no reset, only loaded when a response is captured.
            always_ff @(posedge sys_clk) begin
                if (vld_in) begin
                    data_p0 <= data_in;
                end
            end

            // ---- stage p0 -> core outputs ----
            assign vld_out  = vld_p0;
            assign err_out  = err_p0;
            assign data_out = vld_p0 ? data_p0 : '0;
            assign pending  = vld_p0;
        end else begin : g_pass
            assign vld_out  = vld_in;
            assign err_out  = vld_in & err_in;
            assign data_out = vld_in ? data_in : '0;
            assign pending  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/core_wb_bridge.sv
// Bridge from a simple core request/response port to a pipelined Wishbone
// master. Requests go to the bus unregistered; an outstanding counter limits
// in-flight requests; responses return in order through bridge_resp_stage.
// A watchdog aborts a stuck bus and retires every outstanding request with
// an error response.
module core_wb_bridge
    import core_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int RESP_REG        = DEF_RESP_REG,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    // core request side
    input  logic                    req_rd_i,
    input  logic [DATA_WIDTH/8-1:0] req_wr_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_data_i,
    output logic                    req_accept_o,
    // core response side
    output logic                    resp_valid_o,
    output logic [DATA_WIDTH-1:0]   resp_data_o,
    output logic                    resp_error_o,
    output logic                    busy_o,
    // pipelined Wishbone master
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit               WD_ARMED = (TIMEOUT_CYCLES != 0);

    bridge_state_e          state;
    logic [CNT_W-1:0]       outstanding;
    logic [WD_W-1:0]        wdog;

    logic                   run;
    logic                   req_valid;
    logic                   room;
    logic                   out_nz;
    logic                   accept;
    logic                   bus_rsp;
    logic                   abort_rsp;
    logic                   timeout;

    logic                   rsp_vld_in;
    logic                   rsp_err_in;
    logic [DATA_WIDTH-1:0]  rsp_data_in;
    logic                   rsp_pending;

    // Request qualification, bus strobes and response detection.
    always_comb begin
        run       = (state == RUN) & rst_n;
        req_valid = req_rd_i | (req_wr_i != '0);
        room      = (outstanding < CNT_MAX);
        out_nz    = (outstanding != '0);

        wb_stb_o     = run & req_valid & room;
        accept       = wb_stb_o & ~wb_stall_i;
        req_accept_o = accept;
        wb_cyc_o     = run & (wb_stb_o | out_nz);

        // Write wins over a simultaneous read.
        wb_we_o  = |req_wr_i;
        wb_sel_o = wb_we_o ? req_wr_i : '1;
        wb_adr_o = req_addr_i;
        wb_dat_o = req_data_i;

        // Acks/errs with nothing in flight are stray and dropped.
        bus_rsp   = run & (wb_ack_i | wb_err_i) & out_nz;
        abort_rsp = (state == ABORT) & out_nz;
        timeout   = WD_ARMED & run & out_nz & ~bus_rsp & (wdog == WD_LAST);

        // Abort retirements share the response path, so a response captured
        // in the timeout cycle still leaves ahead of them.
        rsp_vld_in  = bus_rsp | abort_rsp;
        rsp_err_in  = abort_rsp | wb_err_i;
        rsp_data_in = (abort_rsp | wb_err_i) ? '0 : wb_dat_i;

        busy_o = out_nz | rsp_pending;
    end

    // Controller: state, outstanding-request counter and bus watchdog.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            outstanding <= '0;
            wdog        <= '0;
        end else begin
            case (state)
                RUN: begin
                    case ({accept, bus_rsp})
                        2'b10:   outstanding <= outstanding + CNT_ONE;
                        2'b01:   outstanding <= outstanding - CNT_ONE;
                        default: outstanding <= outstanding;
                    endcase
                    if (!out_nz || bus_rsp) begin
                        wdog <= '0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                    if (timeout) begin
                        state <= ABORT;
                    end
                end
                ABORT: begin
                    wdog <= '0;
                    if (out_nz) begin
                        outstanding <= outstanding - CNT_ONE;
                    end
                    // Leave once the last request is being retired this cycle.
                    if (outstanding <= CNT_ONE) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    bridge_resp_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESP_REG   (RESP_REG)
    ) u_resp (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .vld_in   (rsp_vld_in),
        .err_in   (rsp_err_in),
        .data_in  (rsp_data_in),
        .vld_out  (resp_valid_o),
        .err_out  (resp_error_o),
        .data_out (resp_data_o),
        .pending  (rsp_pending)
    );

endmodule

// File: tb/tb_core_wb_bridge.sv
// Directed bench for core_wb_bridge with MAX_OUTSTANDING=2, RESP_REG=1 and
// TIMEOUT_CYCLES=16. Inputs change 1 ns after the rising edge; outputs are
// checked 1 ns after that.
module tb_core_wb_bridge;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        req_rd;
    logic [3:0]  req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_accept;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        busy;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    int n_vec = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    core_wb_bridge #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2),
        .RESP_REG        (1),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .req_rd_i     (req_rd),
        .req_wr_i     (req_wr),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_accept_o (req_accept),
        .resp_valid_o (resp_valid),
        .resp_data_o  (resp_data),
        .resp_error_o (resp_error),
        .busy_o       (busy),
        .wb_cyc_o     (wb_cyc),
        .wb_stb_o     (wb_stb),
        .wb_we_o      (wb_we),
        .wb_sel_o     (wb_sel),
        .wb_adr_o     (wb_adr),
        .wb_dat_o     (wb_dat_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack),
        .wb_err_i     (wb_err),
        .wb_stall_i   (wb_stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n    = 1'b0;
        req_rd   = 1'b1;
        req_wr   = '0;
        req_addr = '0;
        req_data = '0;
        wb_dat_i = '0;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_stall = 1'b0;

        // Reset state, with a read request held high
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_stb",    wb_stb,     0);
        chk("rst_cyc",    wb_cyc,     0);
        chk("rst_accept", req_accept, 0);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rerr",   resp_error, 0);
        chk("rst_rdata",  resp_data,  0);
        chk("rst_busy",   busy,       0);
        req_rd = 1'b0;
        rst_n  = 1'b1;
        tick();

        // Single read at 0x100, acked with 0xDEADBEEF
        req_rd   = 1'b1;
        req_addr = 32'h100;
        #1;
        chk("rd_stb",    wb_stb,     1);
        chk("rd_accept", req_accept, 1);
        chk("rd_sel",    wb_sel,     4'hF);
        chk("rd_we",     wb_we,      0);
        chk("rd_adr",    wb_adr,     32'h100);
        chk("rd_cyc",    wb_cyc,     1);
        tick();
        req_rd   = 1'b0;
        wb_ack   = 1'b1;
        wb_dat_i = 32'hDEADBEEF;
        #1;
        chk("rd_rvalid_early", resp_valid, 0);
        chk("rd_busy",         busy,       1);
        tick();
        wb_ack = 1'b0;
        #1;
        chk("rd_rvalid", resp_valid, 1);
        chk("rd_rdata",  resp_data,  32'hDEADBEEF);
        chk("rd_rerr",   resp_error, 0);
        tick();
        chk("rd_rvalid_off", resp_valid, 0);
        chk("rd_idle_busy",  busy,       0);
        chk("rd_idle_cyc",   wb_cyc,     0);

        // Byte-lane write
        req_wr   = 4'b0011;
        req_data = 32'h1234;
        #1;
        chk("wr_we",     wb_we,      1);
        chk("wr_sel",    wb_sel,     4'b0011);
        chk("wr_dat",    wb_dat_o,   32'h1234);
        chk("wr_accept", req_accept, 1);
        tick();
        req_wr   = '0;
        wb_ack   = 1'b1;
        wb_dat_i = '0;
        tick();
        wb_ack = 1'b0;
        #1;
        chk("wr_rvalid", resp_valid, 1);
        chk("wr_rerr",   resp_error, 0);
        tick();

        // Outstanding limit and stall
        req_rd = 1'b1;
        #1;
        chk("lim_acc1", req_accept, 1);
        tick();
        chk("lim_acc2", req_accept, 1);
        tick();
        chk("lim_full_acc", req_accept, 0);
        chk("lim_full_stb", wb_stb,     0);
        tick();
        chk("lim_still_full", req_accept, 0);
        wb_ack   = 1'b1;
        wb_dat_i = 32'hA1;
        #1;
        chk("lim_ack_cycle", req_accept, 0);
        tick();
        wb_ack   = 1'b0;
        wb_stall = 1'b1;
        #1;
        chk("stall_stb",    wb_stb,     1);
        chk("stall_accept", req_accept, 0);
        chk("lim_r1_valid", resp_valid, 1);
        chk("lim_r1_data",  resp_data,  32'hA1);
        wb_stall = 1'b0;
        #1;
        chk("unstall_accept", req_accept, 1);
        tick();
        req_rd   = 1'b0;
        wb_ack   = 1'b1;
        wb_dat_i = 32'hA2;
        tick();
        wb_dat_i = 32'hA3;
        #1;
        chk("lim_r2_valid", resp_valid, 1);
        chk("lim_r2_data",  resp_data,  32'hA2);
        tick();
        wb_ack = 1'b0;
        chk("lim_r3_valid", resp_valid, 1);
        chk("lim_r3_data",  resp_data,  32'hA3);
        tick();
        chk("lim_idle_busy", busy, 0);

        // Accept and ack together at one outstanding; then a stray ack
        req_rd = 1'b1;
        #1;
        tick();
        wb_ack   = 1'b1;
        wb_dat_i = 32'hB1;
        #1;
        chk("sim_accept", req_accept, 1);
        tick();
        req_rd = 1'b0;
        wb_ack = 1'b0;
        #1;
        chk("sim_held_cyc", wb_cyc,     1);
        chk("sim_r1_valid", resp_valid, 1);
        chk("sim_r1_data",  resp_data,  32'hB1);
        wb_ack   = 1'b1;
        wb_dat_i = 32'hB2;
        tick();
        wb_ack = 1'b0;
        #1;
        chk("sim_drained_cyc", wb_cyc,     0);
        chk("sim_r2_valid",    resp_valid, 1);
        chk("sim_r2_data",     resp_data,  32'hB2);
        tick();
        chk("sim_rvalid_off", resp_valid, 0);
        wb_ack   = 1'b1;
        wb_dat_i = 32'hCC;
        #1;
        chk("stray_cyc", wb_cyc, 0);
        tick();
        wb_ack = 1'b0;
        #1;
        chk("stray_rvalid", resp_valid, 0);
        chk("stray_busy",   busy,       0);

        // Error on the second of three reads
        req_rd = 1'b1;
        #1;
        tick();
        wb_ack   = 1'b1;
        wb_dat_i = 32'h11;
        tick();
        wb_ack   = 1'b0;
        wb_err   = 1'b1;
        wb_dat_i = 32'hBAD;
        #1;
        chk("err_r1_valid", resp_valid, 1);
        chk("err_r1_err",   resp_error, 0);
        chk("err_r1_data",  resp_data,  32'h11);
        tick();
        req_rd   = 1'b0;
        wb_err   = 1'b0;
        wb_ack   = 1'b1;
        wb_dat_i = 32'h33;
        #1;
        chk("err_r2_valid", resp_valid, 1);
        chk("err_r2_err",   resp_error, 1);
        chk("err_r2_data",  resp_data,  0);
        tick();
        wb_ack = 1'b0;
        #1;
        chk("err_r3_valid", resp_valid, 1);
        chk("err_r3_err",   resp_error, 0);
        chk("err_r3_data",  resp_data,  32'h33);
        tick();
        chk("err_idle_busy", busy, 0);

        // Reset with two requests in flight
        req_rd = 1'b1;
        #1;
        tick();
        tick();
        req_rd = 1'b0;
        #1;
        chk("mrst_pre_cyc", wb_cyc, 1);
        rst_n  = 1'b0;
        wb_ack = 1'b1;
        #1;
        chk("mrst_cyc",    wb_cyc,     0);
        chk("mrst_stb",    wb_stb,     0);
        chk("mrst_busy",   busy,       0);
        chk("mrst_rvalid", resp_valid, 0);
        chk("mrst_rdata",  resp_data,  0);
        tick();
        tick();
        wb_ack = 1'b0;
        rst_n  = 1'b1;
        tick();
        wb_ack   = 1'b1;
        wb_dat_i = 32'hEE;
        #1;
        chk("mrst_after_cyc",  wb_cyc, 0);
        chk("mrst_after_busy", busy,   0);
        tick();
        wb_ack = 1'b0;
        #1;
        chk("mrst_no_rvalid", resp_valid, 0);

        // Timeout with two requests never acknowledged
        tick();
        req_rd = 1'b1;
        #1;
        chk("to_acc1", req_accept, 1);
        tick();
        chk("to_acc2", req_accept, 1);
        tick();
        req_rd = 1'b0;
        repeat (14) tick();
        chk("to_cyc_before", wb_cyc, 1);
        tick();
        req_rd = 1'b1;
        #1;
        chk("to_abort_cyc",    wb_cyc,     0);
        chk("to_abort_stb",    wb_stb,     0);
        chk("to_abort_accept", req_accept, 0);
        chk("to_abort_rvalid", resp_valid, 0);
        req_rd = 1'b0;
        tick();
        wb_ack   = 1'b1;
        wb_dat_i = 32'h55;
        #1;
        chk("to_e1_valid", resp_valid, 1);
        chk("to_e1_err",   resp_error, 1);
        chk("to_e1_data",  resp_data,  0);
        tick();
        wb_ack = 1'b0;
        #1;
        chk("to_e2_valid", resp_valid, 1);
        chk("to_e2_err",   resp_error, 1);
        chk("to_e2_data",  resp_data,  0);
        chk("to_e2_busy",  busy,       1);
        tick();
        chk("to_done_rvalid", resp_valid, 0);
        chk("to_done_busy",   busy,       0);
        chk("to_done_cyc",    wb_cyc,     0);
        req_rd = 1'b1;
        #1;
        chk("to_run_accept", req_accept, 1);
        tick();
        req_rd   = 1'b0;
        wb_ack   = 1'b1;
        wb_dat_i = 32'h77;
        tick();
        wb_ack = 1'b0;
        #1;
        chk("to_run_rvalid", resp_valid, 1);
        chk("to_run_rdata",  resp_data,  32'h77);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
